// File: rtl/iconn_merge_arbiter.sv
// Two-input merge node: arbitrates two valid/ready packet streams onto one registered
// output. The smaller destination address wins unless a port has lost MAX_WAIT times in a row.
module iconn_merge_arbiter #(
   parameter int NODE_ADDR_WIDTH = 5,
   parameter int DATA_WIDTH      = 64,
   parameter int MAX_WAIT        = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [1:0]                 in_valid,
   output logic [1:0]                 in_ready,
   input  logic [NODE_ADDR_WIDTH-1:0] in_addr [0:1],
   input  logic [DATA_WIDTH-1:0]      in_data [0:1],
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [NODE_ADDR_WIDTH-1:0] out_addr,
   output logic [DATA_WIDTH-1:0]      out_data,
   output logic                       out_port,
   output logic                       starve_evt
);
   localparam int CNT_W = $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

   logic [CNT_W-1:0]           cnt_q [2];
   logic [CNT_W-1:0]           cnt_d [2];
   logic                       out_valid_q, out_valid_d;
   logic [NODE_ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
   logic [DATA_WIDTH-1:0]      out_data_q, out_data_d;
   logic                       out_port_q, out_port_d;
   logic                       starve_q, starve_d;

   logic load, gnt_vld, gnt_idx, forced, xfer;

   always_comb begin
      load    = !out_valid_q | out_ready;
      gnt_vld = 1'b0;
      gnt_idx = 1'b0;
      forced  = 1'b0;
      case (in_valid)
         2'b01: gnt_vld = 1'b1;
         2'b10: begin
            gnt_vld = 1'b1;
            gnt_idx = 1'b1;
         end
         2'b11: begin
            gnt_vld = 1'b1;
            // Port 0 is checked first; both counters saturated is unreachable.
            if (cnt_q[0] == CNT_MAX) begin
               forced = 1'b1;
            end else if (cnt_q[1] == CNT_MAX) begin
               gnt_idx = 1'b1;
               forced  = 1'b1;
            end else begin
               gnt_idx = !(in_addr[0] < in_addr[1]);
            end
         end
         default: ;
      endcase

      xfer        = rst_n & load & gnt_vld;
      in_ready[0] = xfer & !gnt_idx;
      in_ready[1] = xfer & gnt_idx;

      // Counters age only on transfer cycles; a withdrawn request forfeits its age.
      for (int i = 0; i < 2; i++) begin
         cnt_d[i] = cnt_q[i];
         if (xfer) begin
            if (gnt_idx == i[0]) begin
               cnt_d[i] = '0;
            end else if (in_valid[i]) begin
               cnt_d[i] = (cnt_q[i] == CNT_MAX) ? CNT_MAX : cnt_q[i] + 1'b1;
            end else begin
               cnt_d[i] = '0;
            end
         end
      end

      out_valid_d = out_valid_q;
      out_addr_d  = out_addr_q;
      out_data_d  = out_data_q;
      out_port_d  = out_port_q;
      if (load) begin
         out_valid_d = gnt_vld;
         if (gnt_vld) begin
            out_addr_d = in_addr[gnt_idx];
            out_data_d = in_data[gnt_idx];
            out_port_d = gnt_idx;
         end
      end
      starve_d = xfer & forced;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q[0]    <= '0;
         cnt_q[1]    <= '0;
         out_valid_q <= 1'b0;
         out_addr_q  <= '0;
         out_data_q  <= '0;
         out_port_q  <= 1'b0;
         starve_q    <= 1'b0;
      end else begin
         cnt_q[0]    <= cnt_d[0];
         cnt_q[1]    <= cnt_d[1];
         out_valid_q <= out_valid_d;
         out_addr_q  <= out_addr_d;
         out_data_q  <= out_data_d;
         out_port_q  <= out_port_d;
         starve_q    <= starve_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_addr   = out_addr_q;
   assign out_data   = out_data_q;
   assign out_port   = out_port_q;
   assign starve_evt = starve_q;

endmodule
